// File: rtl/conv_cmd_ctrl_if.sv
// Byte-level link between the SPI slave, the command sequencer and the convolution engine.
// master drives frames/bytes and engine feedback; slave is the sequencer.
interface conv_cmd_ctrl_if #(
    parameter int unsigned W_AW   = 4,
    parameter int unsigned RES_AW = 6
);
    logic              frame_start;
    logic              frame_end;
    logic              byte_valid;
    logic [7:0]        byte_in;
    logic [7:0]        tx_data;
    logic              w_we;
    logic [W_AW-1:0]   w_addr;
    logic [7:0]        w_data;
    logic              px_valid;
    logic [7:0]        px_data;
    logic              conv_start;
    logic              conv_done;
    logic              busy;
    logic [RES_AW-1:0] res_addr;
    logic [7:0]        res_data;

    modport master (
        output frame_start, frame_end, byte_valid, byte_in, conv_done, res_data,
        input  tx_data, w_we, w_addr, w_data, px_valid, px_data, conv_start, busy, res_addr
    );

    modport slave (
        input  frame_start, frame_end, byte_valid, byte_in, conv_done, res_data,
        output tx_data, w_we, w_addr, w_data, px_valid, px_data, conv_start, busy, res_addr
    );
endinterface

// File: rtl/conv_cmd_ctrl.sv
// Command sequencer: turns SSEL-framed SPI byte streams into weight writes, pixel strobes,
// convolution start and result/status readback on MISO.
module conv_cmd_ctrl #(
    parameter int unsigned NUM_W   = 9,
    parameter int unsigned W_AW    = 4,
    parameter int unsigned NUM_PX  = 64,
    parameter int unsigned NUM_RES = 36,
    parameter int unsigned RES_AW  = 6
) (
    input logic           CLK,
    input logic           RESET,
    conv_cmd_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        StIdle, StOpcode, StLoadW, StLoadPx, StRead, StStatus, StDiscard
    } state_e;

    localparam logic [7:0] NumW   = 8'(NUM_W);
    localparam logic [7:0] NumPx  = 8'(NUM_PX);
    localparam logic [7:0] NumRes = 8'(NUM_RES);

    state_e            state_q;
    logic [7:0]        cnt_q;
    logic [7:0]        tx_q;
    logic              tx_sel_q;
    logic              tx_pend_q;
    logic              start_pend_q;
    logic              w_we_q;
    logic [W_AW-1:0]   w_addr_q;
    logic [7:0]        w_data_q;
    logic              px_valid_q;
    logic [7:0]        px_data_q;
    logic              conv_start_q;
    logic              busy_q;
    logic [RES_AW-1:0] res_addr_q;
    logic              done_q;
    logic              err_op_q;
    logic              err_busy_q;
    logic              err_abort_q;

    logic       eng_busy;
    logic       px_last;
    logic       abort;
    logic [7:0] status;

    assign eng_busy = busy_q | start_pend_q;
    assign px_last  = (state_q == StLoadPx) && bus.byte_valid && (cnt_q == NumPx - 8'd1);
    assign abort    = (bus.frame_start || bus.frame_end) && (state_q == StLoadPx) && !px_last;
    assign status   = {3'b000, done_q, err_abort_q, err_busy_q, err_op_q, busy_q};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            tx_q         <= '0;
            tx_sel_q     <= 1'b0;
            tx_pend_q    <= 1'b0;
            start_pend_q <= 1'b0;
            w_we_q       <= 1'b0;
            w_addr_q     <= '0;
            w_data_q     <= '0;
            px_valid_q   <= 1'b0;
            px_data_q    <= '0;
            conv_start_q <= 1'b0;
            busy_q       <= 1'b0;
            res_addr_q   <= '0;
            done_q       <= 1'b0;
            err_op_q     <= 1'b0;
            err_busy_q   <= 1'b0;
            err_abort_q  <= 1'b0;
        end else begin
            w_we_q       <= 1'b0;
            px_valid_q   <= 1'b0;
            conv_start_q <= 1'b0;
            start_pend_q <= 1'b0;
            tx_pend_q    <= 1'b0;

            // Second cycle after the opcode: first MISO byte of the command becomes visible.
            if (tx_pend_q) begin
                case (state_q)
                    StStatus: tx_q     <= status;
                    StRead:   tx_sel_q <= 1'b1;
                    default:  tx_q     <= 8'h00;
                endcase
            end

            if (start_pend_q) begin
                conv_start_q <= 1'b1;
                busy_q       <= 1'b1;
            end else if (busy_q && bus.conv_done) begin
                busy_q <= 1'b0;
                done_q <= 1'b1;
            end

            if (bus.byte_valid) begin
                case (state_q)
                    StOpcode: begin
                        tx_pend_q <= 1'b1;
                        case (bus.byte_in)
                            8'h01: begin
                                if (eng_busy) begin
                                    state_q    <= StDiscard;
                                    err_busy_q <= 1'b1;
                                end else begin
                                    state_q <= StLoadW;
                                    cnt_q   <= '0;
                                end
                            end
                            8'h02: begin
                                if (eng_busy) begin
                                    state_q    <= StDiscard;
                                    err_busy_q <= 1'b1;
                                end else begin
                                    state_q <= StLoadPx;
                                    cnt_q   <= '0;
                                    done_q  <= 1'b0;
                                end
                            end
                            8'h03: begin
                                state_q    <= StRead;
                                res_addr_q <= '0;
                                cnt_q      <= 8'd1;
                            end
                            8'h04:   state_q <= StStatus;
                            default: begin
                                state_q  <= StDiscard;
                                err_op_q <= 1'b1;
                            end
                        endcase
                    end
                    StLoadW: begin
                        if (cnt_q < NumW) begin
                            w_we_q   <= 1'b1;
                            w_addr_q <= cnt_q[W_AW-1:0];
                            w_data_q <= bus.byte_in;
                            cnt_q    <= cnt_q + 8'd1;
                        end
                    end
                    StLoadPx: begin
                        px_valid_q <= 1'b1;
                        px_data_q  <= bus.byte_in;
                        if (px_last) begin
                            start_pend_q <= 1'b1;
                            cnt_q        <= '0;
                            state_q      <= StDiscard;
                        end else begin
                            cnt_q <= cnt_q + 8'd1;
                        end
                    end
                    StRead: begin
                        if (cnt_q < NumRes) begin
                            res_addr_q <= cnt_q[RES_AW-1:0];
                            cnt_q      <= cnt_q + 8'd1;
                        end else begin
                            tx_sel_q <= 1'b0;
                            tx_q     <= 8'h00;
                        end
                    end
                    StStatus: begin
                        err_op_q    <= 1'b0;
                        err_busy_q  <= 1'b0;
                        err_abort_q <= 1'b0;
                    end
                    default: ;
                endcase
            end

            // Frame boundaries win over any byte handled in the same cycle.
            if (bus.frame_start || bus.frame_end) begin
                if (abort) begin
                    err_abort_q <= 1'b1;
                    cnt_q       <= '0;
                end
                if (bus.frame_end && state_q == StStatus) begin
                    err_op_q    <= 1'b0;
                    err_busy_q  <= 1'b0;
                    err_abort_q <= 1'b0;
                end
                state_q   <= bus.frame_start ? StOpcode : StIdle;
                tx_q      <= 8'h00;
                tx_sel_q  <= 1'b0;
                tx_pend_q <= 1'b0;
            end
        end
    end

    // Read data goes straight from result memory once its address has been presented.
    assign bus.tx_data    = tx_sel_q ? bus.res_data : tx_q;
    assign bus.w_we       = w_we_q;
    assign bus.w_addr     = w_addr_q;
    assign bus.w_data     = w_data_q;
    assign bus.px_valid   = px_valid_q;
    assign bus.px_data    = px_data_q;
    assign bus.conv_start = conv_start_q;
    assign bus.busy       = busy_q;
    assign bus.res_addr   = res_addr_q;
endmodule
